// File: rtl/mult_result_display.sv
// mult_result_display
// Captures the 8-bit multiplier product on a rising edge of done_i, converts it
// to 3-digit BCD with a sequential double-dabble (one shift per clock), then
// drives three seven-segment displays and pulses valid_o for one cycle.
//
// Handshake: done_i is a level; only its rising edge starts a conversion, and
// only while idle. A rising edge seen while busy is dropped and latched in the
// sticky overrun_o flag. valid_o is a one-cycle pulse that marks the cycle in
// which bcd_o/hex*_o carry a freshly converted value; those outputs then hold.
module mult_result_display #(
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_i,
    input  logic [7:0]  y_i,
    output logic [11:0] bcd_o,
    output logic [6:0]  hex0_o,
    output logic [6:0]  hex1_o,
    output logic [6:0]  hex2_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_done_q;
    logic [19:0] r_shift;
    logic [2:0]  r_cnt;
    logic [11:0] r_bcd;
    logic [6:0]  r_hex0;
    logic [6:0]  r_hex1;
    logic [6:0]  r_hex2;
    logic        r_valid;
    logic        r_busy;
    logic        r_overrun;

    logic        w_rise;
    logic [19:0] w_adj;
    logic [19:0] w_shift_nxt;
    logic [6:0]  w_hex0;
    logic [6:0]  w_hex1;
    logic [6:0]  w_hex2;
    logic [6:0]  w_blank;
    logic        w_blank2;
    logic        w_blank1;

    // Segment code for one digit in active-low form; out-of-range nibbles blank.
    function automatic logic [6:0] seg_al(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    // Apply board polarity to an active-low code.
    function automatic logic [6:0] seg_pol(input logic [6:0] code_al);
        return SEG_ACTIVE_LOW ? code_al : ~code_al;
    endfunction

    assign w_rise  = done_i & ~r_done_q;
    assign w_blank = seg_pol(7'h7F);

    // Double-dabble correction: add 3 to each BCD nibble >= 5 before the shift.
    always_comb begin
        w_adj = r_shift;
        if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
        if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
        if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
    end

    assign w_shift_nxt = {w_adj[18:0], 1'b0};

    // Leading-zero blanking and decode of the finished BCD digits in r_shift[19:8].
    assign w_blank2 = BLANK_LZ && (r_shift[19:16] == 4'd0);
    assign w_blank1 = BLANK_LZ && (r_shift[19:16] == 4'd0) && (r_shift[15:12] == 4'd0);
    assign w_hex2   = w_blank2 ? w_blank : seg_pol(seg_al(r_shift[19:16]));
    assign w_hex1   = w_blank1 ? w_blank : seg_pol(seg_al(r_shift[15:12]));
    assign w_hex0   = seg_pol(seg_al(r_shift[11:8]));

    // Control FSM, edge detect, conversion datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_done_q  <= 1'b0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_hex0    <= w_blank;
            r_hex1    <= w_blank;
            r_hex2    <= w_blank;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done_q <= done_i;
            r_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_shift <= {12'b0, y_i};
                        r_cnt   <= '0;
                        r_state <= S_CONVERT;
                        r_busy  <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    r_shift <= w_shift_nxt;
                    if (r_cnt == 3'd7) r_state <= S_UPDATE;
                    else               r_cnt   <= r_cnt + 3'd1;
                    if (w_rise) r_overrun <= 1'b1;
                end
                S_UPDATE: begin
                    r_bcd   <= r_shift[19:8];
                    r_hex0  <= w_hex0;
                    r_hex1  <= w_hex1;
                    r_hex2  <= w_hex2;
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (w_rise) r_overrun <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd_o     = r_bcd;
    assign hex0_o    = r_hex0;
    assign hex1_o    = r_hex1;
    assign hex2_o    = r_hex2;
    assign valid_o   = r_valid;
    assign busy_o    = r_busy;
    assign overrun_o = r_overrun;
    assign state_o   = r_state;

endmodule
